cnt_sched_apb: RTL and testbench
================================

Name: cnt_sched_apb

Overview:
- APB-programmable sequencer for a terminal-count counter, the controlled, reusable form of the team's free-running decade counter.
- Software or a hardware strobe starts, stops and configures the count: terminal value, one-shot or periodic mode, and interrupt.
- Sits on the peripheral APB bus.
- Drives the count value, a terminal-count pulse and a level interrupt to neighbouring logic.

Parameters:
APB_ADDR_WIDTH, 8, APB address width; only paddr[3:2] decoded, paddr[1:0] ignored.
APB_DATA_WIDTH, 8, APB data width; must be >= CNT_WIDTH.
CNT_WIDTH, 8, counter and LIMIT width.
LIMIT_RST, 9, LIMIT reset value (decade count 0..9).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB write
paddr  input  APB_ADDR_WIDTH  APB address
pwdata  input  APB_DATA_WIDTH  APB write data
prdata  output  APB_DATA_WIDTH  APB read data
pready  output  1  tied 1, zero wait states
pslverr  output  1  error for undecoded address
ext_start  input  1  hardware start strobe, one clk pulse
cnt_val  output  CNT_WIDTH  current count
tc_pulse  output  1  terminal-count strobe
busy  output  1  high in RUN state
irq  output  1  level interrupt

Behaviour:
- Interface: one clock domain, clk. Reset rst is asynchronous and active-high. On reset:
  - FSM = IDLE.
  - cnt_val = 0, LIMIT = LIMIT_RST, MODE = 0, IRQ_EN = 0, DONE = 0.
  - tc_pulse = 0, busy = 0, irq = 0, prdata = 0, pslverr = 0.
- APB access:
  - Access phase is psel & penable. Writes commit at the clock edge of the access phase.
  - prdata is combinational, valid during the access phase, 0 otherwise.
  - pslverr = 1 only in an access phase to offset 0x10 and above (paddr[APB_ADDR_WIDTH-1:4] != 0); such a write has no effect.
  - Unused register bits read 0.
- Registers:
  - 0x00 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 STOP: write-1 pulse, reads 0.
    - bit2 MODE: R/W, 0 = one-shot, 1 = periodic.
    - bit3 IRQ_EN: R/W.
  - 0x04 LIMIT: R/W, CNT_WIDTH bits.
  - 0x08 STATUS:
    - bit0 BUSY: read-only.
    - bit1 DONE: sticky, write-1-to-clear.
  - 0x0C COUNT: read-only, = cnt_val.
- start = CTRL write with bit0 = 1, OR ext_start.
- stop = CTRL write with bit1 = 1.
- FSM IDLE:
  - cnt_val = 0.
  - start -> RUN, cnt_val stays 0 on the entry edge.
- FSM RUN:
  - cnt_val increments by 1 every cycle, modulo 2^CNT_WIDTH.
  - tc_pulse = (cnt_val == LIMIT), combinational, one cycle wide.
  - On a tc edge in periodic mode: cnt_val -> 0, stay in RUN.
  - On a tc edge in one-shot mode: -> HOLD, cnt_val frozen at LIMIT, DONE set.
  - stop -> HOLD with cnt_val frozen. DONE is not set, and stop wins over a coincident tc.
  - start while in RUN is ignored.
- FSM HOLD:
  - cnt_val holds its value.
  - start -> RUN with cnt_val -> 0.
  - stop has no effect.
- START and STOP written in the same cycle: STOP wins, START is discarded.
- DONE set and a DONE W1C in the same cycle: set wins.
- LIMIT written during RUN takes effect the next cycle; terminal detection is equality only.
  - If cnt_val is already above the new LIMIT, counting continues to 2^CNT_WIDTH-1, wraps to 0, then terminates at LIMIT.
  - LIMIT = 0 in periodic mode: tc_pulse high every cycle.
  - LIMIT = 0 in one-shot mode: HOLD after 1 cycle.
- MODE changed during RUN applies at the next terminal count.
- Start-to-first-tc latency = LIMIT+1 cycles. Periodic tc period = LIMIT+1 cycles.
- busy = (FSM == RUN).
- irq = DONE & IRQ_EN, registered state, no extra latency.
- rst asserted mid-count returns every output to its reset value immediately (asynchronously).

Test Plan:
- Reset, then read all four registers -> CTRL 0x00, LIMIT 0x09, STATUS 0x00, COUNT 0x00; read 0x10 -> pslverr = 1, prdata = 0.
- MODE = 0, IRQ_EN = 1, write START -> cnt_val steps 0..9; tc_pulse high exactly on the 10th cycle after the START edge; then HOLD at 9, STATUS = 0x02, irq = 1; write STATUS 0x02 -> irq = 0.
- MODE = 1, LIMIT = 3, ext_start pulse -> tc_pulse every 4 cycles, cnt_val 0,1,2,3,0...; write STOP at cnt_val = 2 -> cnt_val holds 2, busy = 0, DONE = 0.
- In RUN with cnt_val = 7, write LIMIT = 4 -> count continues 8..255, wraps to 0, tc fires at 4; a CTRL write of 0x03 from HOLD leaves the block in HOLD.
- Assert rst at cnt_val = 5 in periodic RUN -> all outputs 0 immediately and LIMIT reads 9; coincident tc and W1C of DONE in one-shot -> DONE reads 1.

Source files
------------

// File: rtl/cnt_sched_apb.sv
// APB-controlled terminal-count counter sequencer.
// Supports software or ext_start start, one-shot or periodic mode, a sticky DONE flag and a level interrupt.
module cnt_sched_apb #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int LIMIT_RST      = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [APB_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic                      ext_start,
    output logic [CNT_WIDTH-1:0]      cnt_val,
    output logic                      tc_pulse,
    output logic                      busy,
    output logic                      irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LIMIT_INIT = CNT_WIDTH'(LIMIT_RST);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] limit_q, limit_d;
    logic                 mode_q, mode_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;

    logic       access;
    logic       addr_err;
    logic       wr_ok;
    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       limit_wr;
    logic       status_wr;
    logic       start_req;
    logic       stop_req;
    logic       tc;
    logic       done_set;
    logic       unused_bits;

    assign access    = psel & penable;
    assign addr_err  = |paddr[APB_ADDR_WIDTH-1:4];
    assign wr_ok     = access & pwrite & ~addr_err;
    assign reg_sel   = paddr[3:2];
    assign ctrl_wr   = wr_ok && (reg_sel == REG_CTRL);
    assign limit_wr  = wr_ok && (reg_sel == REG_LIMIT);
    assign status_wr = wr_ok && (reg_sel == REG_STATUS);

    // A stop in the same cycle discards any start, including ext_start.
    assign stop_req  = ctrl_wr & pwdata[1];
    assign start_req = ((ctrl_wr & pwdata[0]) | ext_start) & ~stop_req;

    assign tc          = (state_q == ST_RUN) && (cnt_q == limit_q);
    assign unused_bits = ^{paddr[1:0], pwdata};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d = ST_HOLD;
                end else if (tc) begin
                    if (mode_q) begin
                        cnt_d = '0;
                    end else begin
                        state_d  = ST_HOLD;
                        done_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (start_req) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        limit_d  = limit_q;
        done_d   = done_q;
        if (ctrl_wr) begin
            mode_d   = pwdata[2];
            irq_en_d = pwdata[3];
        end
        if (limit_wr) begin
            limit_d = pwdata[CNT_WIDTH-1:0];
        end
        if (status_wr && pwdata[1]) begin
            done_d = 1'b0;
        end
        // A terminal count landing on the clear cycle must not be lost.
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            limit_q  <= LIMIT_INIT;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            limit_q  <= limit_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        prdata = '0;
        if (access && !addr_err) begin
            case (reg_sel)
                REG_CTRL:   prdata[3:0] = {irq_en_q, mode_q, 2'b00};
                REG_LIMIT:  prdata[CNT_WIDTH-1:0] = limit_q;
                REG_STATUS: prdata[1:0] = {done_q, busy};
                REG_COUNT:  prdata[CNT_WIDTH-1:0] = cnt_q;
                default:    prdata = '0;
            endcase
        end
    end

    assign pready   = 1'b1;
    assign pslverr  = access & addr_err;
    assign cnt_val  = cnt_q;
    assign tc_pulse = tc;
    assign busy     = (state_q == ST_RUN);
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_cnt_sched_apb.sv
// Directed self-checking bench for cnt_sched_apb; inputs change and outputs are sampled on the falling edge.
module tb_cnt_sched_apb;

    logic       clk;
    logic       rst;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       ext_start;
    logic [7:0] cnt_val;
    logic       tc_pulse;
    logic       busy;
    logic       irq;

    int checks;
    int errors;

    cnt_sched_apb #(
        .APB_ADDR_WIDTH(8),
        .APB_DATA_WIDTH(8),
        .CNT_WIDTH(8),
        .LIMIT_RST(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .ext_start(ext_start),
        .cnt_val(cnt_val),
        .tc_pulse(tc_pulse),
        .busy(busy),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Called on a falling edge; the write commits on the second following rising edge.
    task automatic apb_wr(input logic [7:0] addr, input logic [7:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input string tag, input logic [7:0] addr,
                          input logic [7:0] exp_data, input logic exp_err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk({tag, ".prdata"}, 32'(prdata), 32'(exp_data));
        chk({tag, ".pslverr"}, 32'(pslverr), 32'(exp_err));
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        ext_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and register map
        chk("rst.cnt_val", 32'(cnt_val), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.irq", 32'(irq), 32'h0);
        chk("rst.tc_pulse", 32'(tc_pulse), 32'h0);
        chk("rst.prdata_idle", 32'(prdata), 32'h0);
        chk("rst.pready", 32'(pready), 32'h1);
        apb_rd("rst.CTRL", 8'h00, 8'h00, 1'b0);
        apb_rd("rst.LIMIT", 8'h04, 8'h09, 1'b0);
        apb_rd("rst.STATUS", 8'h08, 8'h00, 1'b0);
        apb_rd("rst.COUNT", 8'h0C, 8'h00, 1'b0);
        apb_rd("rst.BAD", 8'h10, 8'h00, 1'b1);
        apb_wr(8'h14, 8'h55);
        apb_rd("badwr.LIMIT", 8'h04, 8'h09, 1'b0);

        // One-shot 0..9 with interrupt
        apb_wr(8'h00, 8'h09);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("os.cnt[%0d]", i), 32'(cnt_val), 32'(i));
            chk($sformatf("os.tc[%0d]", i), 32'(tc_pulse), 32'(i == 9));
            @(negedge clk);
        end
        chk("os.hold_cnt", 32'(cnt_val), 32'd9);
        chk("os.busy", 32'(busy), 32'h0);
        chk("os.irq", 32'(irq), 32'h1);
        apb_rd("os.STATUS", 8'h08, 8'h02, 1'b0);
        apb_wr(8'h08, 8'h02);
        chk("os.irq_clr", 32'(irq), 32'h0);

        // Periodic LIMIT=3 via ext_start, then STOP at cnt_val=2
        apb_wr(8'h00, 8'h04);
        apb_wr(8'h04, 8'h03);
        ext_start = 1'b1;
        @(negedge clk);
        ext_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("per.cnt[%0d]", i), 32'(cnt_val), 32'(i % 4));
            chk($sformatf("per.tc[%0d]", i), 32'(tc_pulse), 32'((i % 4) == 3));
            chk($sformatf("per.busy[%0d]", i), 32'(busy), 32'h1);
            @(negedge clk);
        end
        apb_wr(8'h00, 8'h06);
        chk("stop.cnt", 32'(cnt_val), 32'd2);
        chk("stop.busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("stop.cnt_held", 32'(cnt_val), 32'd2);
        apb_rd("stop.STATUS", 8'h08, 8'h00, 1'b0);

        // LIMIT lowered below cnt_val mid-run: wrap through 255 then stop at 4
        apb_wr(8'h00, 8'h00);
        apb_wr(8'h04, 8'h09);
        apb_wr(8'h00, 8'h01);
        repeat (6) @(negedge clk);
        chk("lim.cnt6", 32'(cnt_val), 32'd6);
        apb_wr(8'h04, 8'h04);
        for (int i = 8; i <= 260; i++) begin
            chk($sformatf("wrap.cnt[%0d]", i), 32'(cnt_val), 32'(i % 256));
            chk($sformatf("wrap.tc[%0d]", i), 32'(tc_pulse), 32'(i == 260));
            @(negedge clk);
        end
        chk("wrap.hold_cnt", 32'(cnt_val), 32'd4);
        chk("wrap.busy", 32'(busy), 32'h0);
        apb_wr(8'h00, 8'h03);
        chk("startstop.busy", 32'(busy), 32'h0);
        chk("startstop.cnt", 32'(cnt_val), 32'd4);
        apb_rd("wrap.STATUS", 8'h08, 8'h02, 1'b0);
        apb_wr(8'h08, 8'h02);

        // Asynchronous reset in periodic RUN at cnt_val=5
        apb_wr(8'h04, 8'h09);
        apb_wr(8'h00, 8'h0D);
        repeat (5) @(negedge clk);
        chk("pre_rst.cnt", 32'(cnt_val), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.cnt_val", 32'(cnt_val), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.tc_pulse", 32'(tc_pulse), 32'h0);
        chk("arst.irq", 32'(irq), 32'h0);
        chk("arst.prdata", 32'(prdata), 32'h0);
        chk("arst.pslverr", 32'(pslverr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apb_rd("arst.LIMIT", 8'h04, 8'h09, 1'b0);
        apb_rd("arst.CTRL", 8'h00, 8'h00, 1'b0);

        // One-shot tc coinciding with DONE W1C: set wins
        apb_wr(8'h04, 8'h03);
        apb_wr(8'h00, 8'h01);
        repeat (2) @(negedge clk);
        chk("coin.cnt2", 32'(cnt_val), 32'd2);
        apb_wr(8'h08, 8'h02);
        apb_rd("coin.STATUS", 8'h08, 8'h02, 1'b0);
        apb_rd("coin.COUNT", 8'h0C, 8'h03, 1'b0);

        // LIMIT=0 periodic: tc every cycle
        apb_wr(8'h04, 8'h00);
        apb_wr(8'h00, 8'h05);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lim0.cnt[%0d]", i), 32'(cnt_val), 32'h0);
            chk($sformatf("lim0.tc[%0d]", i), 32'(tc_pulse), 32'h1);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
